tag_rr_arbiter: RTL and testbench

- Shares one tagged fabric channel among NUM_IN untagged producers.
- Each cycle it picks one valid requester by round-robin and prepends tag = TAG_BASE + index.
- It drives the result through a single-entry output register.
- A downstream del_tag strips the tag, or a tag-demux routes on it. The tag lets consumers recover which producer sent each word.

---
 rtl/tag_rr_arbiter_pkg.sv | 23 ++
 rtl/tag_rr_arbiter_if.sv | 31 +++
 rtl/tag_rr_arbiter_core.sv | 41 ++++
 rtl/tag_rr_arbiter.sv | 92 +++++++++
 tb/tb_tag_rr_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tag_rr_arbiter_pkg.sv
// Shared definitions for the tagged round-robin arbiter slice.
//   out_state_e : occupancy of the single-entry output register
//   clog2_min1  : ceil(log2(n)), never less than 1, for index widths
package tag_rr_arbiter_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic int clog2_min1(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tag_rr_arbiter_if.sv
// Handshake bundle between NUM_IN untagged producers, the arbiter and the
// tagged fabric channel.
//   in_valid/in_ready/in_data : per-requester handshake, requester i payload
//                               at in_data[i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready       : tagged output handshake
//   out_data                  : {tag, payload}, tag in the MSBs
// Modports: slave = arbiter view, master = producer/consumer view.
interface tag_rr_arbiter_if #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);

  logic [NUM_IN-1:0]              in_valid;
  logic [NUM_IN-1:0]              in_ready;
  logic [NUM_IN*DATA_WIDTH-1:0]   in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [TAG_WIDTH+DATA_WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/tag_rr_arbiter_core.sv
// Purely combinational round-robin grant search, reusable by tag-demux and
// crossbar blocks.
//   req       : request vector
//   ptr       : index holding highest priority this cycle
//   grant     : one-hot grant (all-zero when nothing requests)
//   grant_idx : binary index of the granted requester
//   grant_any : at least one request present
module rr_arbiter_core
  import tag_rr_arbiter_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = clog2_min1(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_any
);

  // Walk offsets from the far end back toward ptr so the closest requester
  // (smallest offset from ptr, modulo NUM_IN) is the last one written.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] idx_w;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      idx_w = IDX_W'(idx);
      if (req[idx_w]) begin
        grant_any = 1'b1;
        grant_idx = idx_w;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/tag_rr_arbiter.sv
// Shares one tagged fabric channel among NUM_IN untagged producers. A
// round-robin search picks one valid requester, its payload is prefixed with
// tag = TAG_BASE + index and loaded into a single-entry output register.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : handshake bundle (slave modport), see tag_rr_arbiter_if
module tag_rr_arbiter
  import tag_rr_arbiter_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int TAG_BASE   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  tag_rr_arbiter_if.slave bus
);

  localparam int IDX_W = clog2_min1(NUM_IN);
  localparam int OUT_W = TAG_WIDTH + DATA_WIDTH;

  if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
    $fatal(1, "tag_rr_arbiter: NUM_IN must be within 2..16");
  end
  if (64'(TAG_BASE + NUM_IN - 1) >= (64'd1 << TAG_WIDTH)) begin : g_bad_tag
    $fatal(1, "tag_rr_arbiter: TAG_BASE+NUM_IN-1 does not fit in TAG_WIDTH");
  end

  logic [NUM_IN-1:0]     grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [IDX_W-1:0]      rr_ptr;
  logic                  can_load;
  logic                  load;
  logic                  out_valid;
  logic [TAG_WIDTH-1:0]  tag_d;
  logic [DATA_WIDTH-1:0] payload_d;
  logic [OUT_W-1:0]      data_q;
  out_state_e            state_q;
  out_state_e            state_d;

  rr_arbiter_core #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_core (
    .req       (bus.in_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign can_load = (state_q == OUT_EMPTY) || bus.out_ready;
  // rst_n gates the handshake so nothing is offered while reset is held.
  assign load     = rst_n && grant_any && can_load;
  assign bus.in_ready = load ? grant : '0;

  assign tag_d     = TAG_WIDTH'(TAG_BASE + int'(grant_idx));
  assign payload_d = bus.in_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OUT_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (load)                                     state_d = OUT_FULL;
    else if (state_q == OUT_FULL && bus.out_ready) state_d = OUT_EMPTY;
  end

  always_comb begin
    out_valid = (state_q == OUT_FULL);
  end

  // Data and pointer only move on an accepted transfer; a drain leaves the
  // last word visible on out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      rr_ptr <= '0;
    end else if (load) begin
      data_q <= {tag_d, payload_d};
      rr_ptr <= (grant_idx == IDX_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_tag_rr_arbiter.sv
module tb_tag_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tag_rr_arbiter_if #(.NUM_IN(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();
  tag_rr_arbiter_if #(.NUM_IN(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus_a ();

  tag_rr_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .TAG_BASE(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  tag_rr_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .TAG_BASE(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = '1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = $urandom;
    bus_a.in_valid = '0;
    bus_a.in_data = '0;
    bus_a.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_data !== 36'h0) begin
      n_bad++; $display("FAIL reset_out_data: got %h want 0", bus.out_data);
    end
    n_cmp++;
    if (bus.in_ready !== 4'b0000) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready);
    end
    n_cmp++;
    if (bus_a.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_a_out_valid: got %b want 0", bus_a.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = '0;
    tick();
  endtask

  task automatic test_single();
    bus.in_valid = 4'b0001;
    bus.in_data[0 +: DW] = 32'hDEAD_BEEF;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 4'b0001) begin
      n_bad++; $display("FAIL single_in_ready: got %b want 0001", bus.in_ready);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_pre_valid: got %b want 0", bus.out_valid);
    end
    tick();
    bus.in_valid = '0;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 36'h0_DEAD_BEEF) begin
      n_bad++; $display("FAIL single_out: got v=%b d=%h want v=1 d=0deadbeef", bus.out_valid, bus.out_data);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 36'h0_DEAD_BEEF) begin
      n_bad++; $display("FAIL single_drain: got v=%b d=%h want v=0 d=0deadbeef", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    bus.in_valid = 4'b1111;
    for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = 32'h1000_0000 + i;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 4'(1 << (k % N))) begin
        n_bad++; $display("FAIL contention_ready[%0d]: got %b want %b", k, bus.in_ready, 4'(1 << (k % N)));
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== {4'(k % N), 32'h1000_0000 + 32'(k % N)}) begin
        n_bad++; $display("FAIL contention_out[%0d]: got v=%b d=%h want tag %0d", k, bus.out_valid, bus.out_data, k % N);
      end
    end
    bus.in_valid = '0;
    tick();
  endtask

  task automatic test_tag_base();
    bus_a.in_valid = 4'b0100;
    bus_a.in_data[2*DW +: DW] = 32'h1234_5678;
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus_a.in_ready !== 4'b0100) begin
      n_bad++; $display("FAIL tagbase_ready: got %b want 0100", bus_a.in_ready);
    end
    tick();
    bus_a.in_valid = '0;
    n_cmp++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 36'hC_1234_5678) begin
      n_bad++; $display("FAIL tagbase_out: got v=%b d=%h want v=1 d=c12345678", bus_a.out_valid, bus_a.out_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.in_valid = 4'b0001;
    bus.in_data[0 +: DW] = 32'hAAAA_0000;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 4'b1010;
    bus.in_data[1*DW +: DW] = 32'hBBBB_1111;
    bus.in_data[3*DW +: DW] = 32'hCCCC_3333;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 4'b0000) begin
        n_bad++; $display("FAIL stall_ready[%0d]: got %b want 0000", k, bus.in_ready);
      end
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 36'h0_AAAA_0000) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got v=%b d=%h want v=1 d=0aaaa0000", k, bus.out_valid, bus.out_data);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 4'b0010) begin
      n_bad++; $display("FAIL release_ready1: got %b want 0010", bus.in_ready);
    end
    tick();
    bus.in_valid = 4'b1000;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 36'h1_BBBB_1111) begin
      n_bad++; $display("FAIL release_out1: got v=%b d=%h want v=1 d=1bbbb1111", bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 4'b1000) begin
      n_bad++; $display("FAIL release_ready3: got %b want 1000", bus.in_ready);
    end
    tick();
    bus.in_valid = '0;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 36'h3_CCCC_3333) begin
      n_bad++; $display("FAIL release_out3: got v=%b d=%h want v=1 d=3cccc3333", bus.out_valid, bus.out_data);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL release_empty: got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.in_valid = 4'b0001;
    bus.in_data[0 +: DW] = 32'h5555_0000;
    bus.in_data[3*DW +: DW] = 32'h5555_3333;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = '0;
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL midrst_pre_valid: got %b want 1", bus.out_valid);
    end
    #2;
    rst_n = 1'b0;
    bus.in_valid = 4'b1001;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 36'h0) begin
      n_bad++; $display("FAIL midrst_async: got v=%b d=%h want v=0 d=0", bus.out_valid, bus.out_data);
    end
    n_cmp++;
    if (bus.in_ready !== 4'b0000) begin
      n_bad++; $display("FAIL midrst_ready: got %b want 0000", bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b0001) begin
      n_bad++; $display("FAIL midrst_grant0: got %b want 0001", bus.in_ready);
    end
    tick();
    bus.in_valid = 4'b1000;
    n_cmp++;
    if (bus.out_data !== 36'h0_5555_0000) begin
      n_bad++; $display("FAIL midrst_out0: got %h want 055550000", bus.out_data);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 4'b1000) begin
      n_bad++; $display("FAIL midrst_grant3: got %b want 1000", bus.in_ready);
    end
    tick();
    bus.in_valid = '0;
    n_cmp++;
    if (bus.out_data !== 36'h3_5555_3333) begin
      n_bad++; $display("FAIL midrst_out3: got %h want 355553333", bus.out_data);
    end
    tick();
  endtask

  task automatic test_single_stream();
    apply_reset();
    bus.in_valid = 4'b1000;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.in_data[3*DW +: DW] = 32'h3000_0000 + k;
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 4'b1000) begin
        n_bad++; $display("FAIL stream_ready[%0d]: got %b want 1000", k, bus.in_ready);
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== {4'd3, 32'h3000_0000 + 32'(k)}) begin
        n_bad++; $display("FAIL stream_out[%0d]: got v=%b d=%h want tag 3 word %0d", k, bus.out_valid, bus.out_data, k);
      end
    end
    bus.in_valid = 4'b1111;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 4'b0001) begin
      n_bad++; $display("FAIL stream_ptr_wrap: got %b want 0001", bus.in_ready);
    end
    tick();
    bus.in_valid = '0;
    tick();
  endtask

  // Reference: priority list of requester indices; the served requester
  // moves to the back of the list.
  task automatic test_random();
    logic [N-1:0]    v;
    logic [DW-1:0]   d [N];
    int              order [$];
    bit              m_full;
    logic [TW+DW-1:0] m_data;
    int              g;
    logic [N-1:0]    exp_rdy;
    bit              ordy;
    apply_reset();
    v = '0;
    order = {0, 1, 2, 3};
    m_full = 1'b0;
    m_data = '0;
    for (int i = 0; i < N; i++) d[i] = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          d[i] = $urandom;
        end
      end
      ordy = ($urandom_range(0, 3) != 0);
      bus.in_valid = v;
      for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = d[i];
      bus.out_ready = ordy;
      @(negedge clk);
      g = -1;
      for (int k = 0; k < N; k++) if (g < 0 && v[order[k]]) g = order[k];
      exp_rdy = (g >= 0 && (!m_full || ordy)) ? 4'(1 << g) : 4'b0;
      n_cmp++;
      if (bus.in_ready !== exp_rdy) begin
        n_bad++; $display("FAIL rand_ready[%0d]: got %b want %b", c, bus.in_ready, exp_rdy);
      end
      n_cmp++;
      if (bus.out_valid !== m_full || bus.out_data !== m_data) begin
        n_bad++; $display("FAIL rand_out[%0d]: got v=%b d=%h want v=%b d=%h", c, bus.out_valid, bus.out_data, m_full, m_data);
      end
      if (exp_rdy != 0) begin
        m_data = {4'(g), d[g]};
        m_full = 1'b1;
        while (order[0] != g) order.push_back(order.pop_front());
        order.push_back(order.pop_front());
        v[g] = 1'b0;
      end else if (ordy) begin
        m_full = 1'b0;
      end
      tick();
    end
    bus.in_valid = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_tag_base();
    test_backpressure();
    test_reset_mid();
    test_single_stream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
